// File: rtl/bt656_stream_gen.sv
// bt656_stream_gen
//   Source-side BT.656/DVP stream emulator. Produces complete YCbCr 4:2:2
//   frames, one byte per clock, with embedded EAV/SAV timing codes and the
//   parallel HREF/HSYNC/VSYNC strobes aligned to each byte.
//
// Ports
//   clk_i          stream pixel clock
//   rstn_i         asynchronous active-low reset
//   enable_i       run request (level); a running frame always completes
//   pattern_sel_i  0 ramp, 1 flat white, 2 line number, 3 checker
//   sensor_rstn_i  sensor reset (active low); low forces idle immediately
//   sensor_pwdn_i  sensor power-down (active high); high forces idle immediately
//   data_o         stream byte
//   href_o         high on active bytes of active lines
//   hsync_o        high from EAV byte 0 through the last blanking byte
//   vsync_o        high on every byte of the first VSYNC_LINES lines
//   busy_o         high while a frame is being emitted
//   frame_cnt_o    completed frame count, wraps at 16 bits
module bt656_stream_gen #(
  parameter int DW          = 8,
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 268,
  parameter int V_ACTIVE    = 480,
  parameter int V_BLANK     = 45,
  parameter int VSYNC_LINES = 3
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          enable_i,
  input  logic [1:0]    pattern_sel_i,
  input  logic          sensor_rstn_i,
  input  logic          sensor_pwdn_i,
  output logic [DW-1:0] data_o,
  output logic          href_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          busy_o,
  output logic [15:0]   frame_cnt_o
);

  localparam int LINE_BYTES  = 8 + H_BLANK + 2 * H_ACTIVE;
  localparam int FRAME_LINES = V_BLANK + V_ACTIVE;
  localparam int HW          = $clog2(LINE_BYTES);
  localparam int VW          = $clog2(FRAME_LINES);

  localparam logic [HW-1:0] H_LAST = HW'(LINE_BYTES - 1);
  localparam logic [HW-1:0] H_EAV3 = HW'(3);
  localparam logic [HW-1:0] H_FILL = HW'(4);
  localparam logic [HW-1:0] H_SAV  = HW'(4 + H_BLANK);
  localparam logic [HW-1:0] H_SAV3 = HW'(7 + H_BLANK);
  localparam logic [HW-1:0] H_ACT  = HW'(8 + H_BLANK);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);
  localparam logic [VW-1:0] V_ACT0 = VW'(V_BLANK);
  localparam logic [VW-1:0] V_SYNC = VW'(VSYNC_LINES);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  // Timing reference status byte with F fixed at 0:
  // {1, F, V, H, V^H, F^H, F^V, F^V^H}
  function automatic logic [7:0] xy_code(input logic v, input logic h);
    return {1'b1, 1'b0, v, h, v ^ h, h, v, v ^ h};
  endfunction

  // Reserve 0x00 and 0xFF for timing codes.
  function automatic logic [7:0] clip_byte(input logic [7:0] b);
    if (b == 8'h00)      return 8'h01;
    else if (b == 8'hFF) return 8'hFE;
    else                 return b;
  endfunction

  state_t          state, state_nxt;
  logic            run_ok, start;
  logic            emit, load_frame, frame_last;

  logic [HW-1:0]   h_cnt_p0;
  logic [VW-1:0]   v_cnt_p0;
  logic [1:0]      pat_p0;

  logic            blank_line;
  logic [7:0]      k;
  logic [7:0]      line;
  logic [7:0]      raw;
  logic [DW-1:0]   byte_p0;

  logic [DW-1:0]   data_p1;
  logic            href_p1, hsync_p1, vsync_p1, vld_p1;
  logic            done_p1;
  logic [15:0]     frame_cnt;

  assign run_ok     = sensor_rstn_i & ~sensor_pwdn_i;
  assign start      = enable_i & run_ok;
  assign frame_last = (h_cnt_p0 == H_LAST) && (v_cnt_p0 == V_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    emit       = 1'b0;
    load_frame = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = RUN;
          load_frame = 1'b1;
        end
      end
      RUN: begin
        if (!run_ok) begin
          state_nxt = IDLE;
        end else begin
          emit = 1'b1;
          if (frame_last) begin
            if (start) load_frame = 1'b1;
            else       state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: stream position and per-frame pattern ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
      pat_p0   <= '0;
    end else begin
      if (emit && !frame_last) begin
        if (h_cnt_p0 == H_LAST) begin
          h_cnt_p0 <= '0;
          v_cnt_p0 <= v_cnt_p0 + 1'b1;
        end else begin
          h_cnt_p0 <= h_cnt_p0 + 1'b1;
        end
      end else begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= '0;
      end
      if (load_frame) pat_p0 <= pattern_sel_i;
    end
  end

  assign blank_line = v_cnt_p0 < V_ACT0;
  assign k          = 8'(h_cnt_p0 - H_ACT);
  assign line       = 8'(v_cnt_p0 - V_ACT0);

  always_comb begin
    raw     = 8'h00;
    byte_p0 = 8'h00;
    if (h_cnt_p0 < H_FILL) begin
      if (h_cnt_p0 == '0)         byte_p0 = 8'hFF;
      else if (h_cnt_p0 == H_EAV3) byte_p0 = xy_code(blank_line, 1'b1);
      else                        byte_p0 = 8'h00;
    end else if (h_cnt_p0 < H_SAV) begin
      byte_p0 = h_cnt_p0[0] ? 8'h10 : 8'h80;
    end else if (h_cnt_p0 < H_ACT) begin
      if (h_cnt_p0 == H_SAV)       byte_p0 = 8'hFF;
      else if (h_cnt_p0 == H_SAV3) byte_p0 = xy_code(blank_line, 1'b0);
      else                         byte_p0 = 8'h00;
    end else if (blank_line) begin
      byte_p0 = k[0] ? 8'h10 : 8'h80;
    end else begin
      case (pat_p0)
        2'd0: raw = k;
        2'd1: raw = k[0] ? 8'hEB : 8'h80;
        2'd2: raw = line;
        // k[4] is bit 3 of the pixel index k>>1.
        default: raw = k[0] ? ((k[4] ^ line[3]) ? 8'hEB : 8'h10) : 8'h80;
      endcase
      byte_p0 = clip_byte(raw);
    end
  end

  // ---- stage p1: registered stream outputs ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_p1   <= '0;
      href_p1   <= 1'b0;
      hsync_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      done_p1   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (emit) begin
        data_p1  <= byte_p0;
        href_p1  <= !blank_line && (h_cnt_p0 >= H_ACT);
        hsync_p1 <= h_cnt_p0 < H_SAV;
        vsync_p1 <= v_cnt_p0 < V_SYNC;
        vld_p1   <= 1'b1;
      end else begin
        data_p1  <= '0;
        href_p1  <= 1'b0;
        hsync_p1 <= 1'b0;
        vsync_p1 <= 1'b0;
        vld_p1   <= 1'b0;
      end
      // Count lands one edge after the last byte is presented.
      done_p1 <= emit && frame_last;
      if (done_p1) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign data_o      = data_p1;
  assign href_o      = href_p1;
  assign hsync_o     = hsync_p1;
  assign vsync_o     = vsync_p1;
  assign busy_o      = vld_p1;
  assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_bt656_stream_gen.sv
// tb_bt656_stream_gen
//   Scoreboard bench for bt656_stream_gen with a 20-byte line, 4-line frame.
module tb_bt656_stream_gen;

  localparam int LB = 20;
  localparam int FB = 80;
  localparam int VB = 2;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        sensor_rstn;
  logic        sensor_pwdn;
  logic [7:0]  data;
  logic        href, hsync, vsync, busy;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0]  d;
    logic [3:0]  f;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];

  bit          m_run  = 0;
  bit          m_done = 0;
  int          m_pos  = 0;
  logic [1:0]  m_pat  = 0;
  logic [15:0] m_fc   = 0;

  bt656_stream_gen #(
    .DW(8), .H_ACTIVE(4), .H_BLANK(4), .V_ACTIVE(2), .V_BLANK(2), .VSYNC_LINES(1)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .enable_i(enable),
    .pattern_sel_i(pattern_sel),
    .sensor_rstn_i(sensor_rstn),
    .sensor_pwdn_i(sensor_pwdn),
    .data_o(data),
    .href_o(href),
    .hsync_o(hsync),
    .vsync_o(vsync),
    .busy_o(busy),
    .frame_cnt_o(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Expected stream byte for frame position pos (0..79) under pattern pat.
  function automatic logic [7:0] ref_byte(input int pos, input logic [1:0] pat);
    int ln, h, k, a;
    bit act;
    logic [7:0] b;
    ln  = pos / LB;
    h   = pos % LB;
    act = (ln >= VB);
    k   = h - 12;
    a   = ln - VB;
    case (h)
      0, 8:         b = 8'hFF;
      1, 2, 9, 10:  b = 8'h00;
      3:            b = act ? 8'h9D : 8'hB6;
      11:           b = act ? 8'h80 : 8'hAB;
      4, 6:         b = 8'h80;
      5, 7:         b = 8'h10;
      default: begin
        if (!act) b = (k % 2 == 0) ? 8'h80 : 8'h10;
        else begin
          case (pat)
            2'd0: b = 8'(k);
            2'd1: b = (k % 2 == 0) ? 8'h80 : 8'hEB;
            2'd2: b = 8'(a);
            default: b = (k % 2 == 0) ? 8'h80 :
                         ((((k / 2) / 8) % 2) != ((a / 8) % 2)) ? 8'hEB : 8'h10;
          endcase
          if (b == 8'h00) b = 8'h01;
          if (b == 8'hFF) b = 8'hFE;
        end
      end
    endcase
    return b;
  endfunction

  // {href, hsync, vsync, busy} for frame position pos.
  function automatic logic [3:0] ref_flags(input int pos);
    int ln, h;
    ln = pos / LB;
    h  = pos % LB;
    return {(ln >= VB) && (h >= 12), h < 8, ln < 1, 1'b1};
  endfunction

  // Reference: predicts the outputs that will follow each clock edge.
  always @(posedge clk) begin
    exp_t e;
    bit ok, st;
    if (!rstn) begin
      m_run  = 0;
      m_done = 0;
      m_pos  = 0;
      m_fc   = 16'h0;
      e      = '{d: 8'h00, f: 4'h0, fc: 16'h0};
    end else begin
      ok = sensor_rstn && !sensor_pwdn;
      st = ok && enable;
      if (m_done) m_fc = m_fc + 16'd1;
      m_done = 0;
      if (m_run && ok) begin
        e = '{d: ref_byte(m_pos, m_pat), f: ref_flags(m_pos), fc: m_fc};
        if (m_pos == FB - 1) begin
          m_done = 1;
          if (st) begin
            m_pos = 0;
            m_pat = pattern_sel;
          end else begin
            m_run = 0;
          end
        end else begin
          m_pos++;
        end
      end else begin
        e = '{d: 8'h00, f: 4'h0, fc: m_fc};
        if (!m_run && st) begin
          m_run = 1;
          m_pos = 0;
          m_pat = pattern_sel;
        end else begin
          m_run = 0;
        end
      end
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_depth", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk("data", {24'h0, data}, {24'h0, e.d});
      chk("href_hsync_vsync_busy", {28'h0, href, hsync, vsync, busy}, {28'h0, e.f});
      chk("frame_cnt", {16'h0, frame_cnt}, {16'h0, e.fc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    sensor_rstn = 1'b1;
    sensor_pwdn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'h0, data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Three back-to-back frames; pattern changes land at frame boundaries.
    enable = 1'b1;
    repeat (100) @(negedge clk);
    pattern_sel = 2'd1;
    repeat (100) @(negedge clk);
    pattern_sel = 2'd2;
    repeat (42) @(negedge clk);
    chk("fc_three_frames", {16'h0, frame_cnt}, 32'd3);
    chk("busy_running", {31'h0, busy}, 32'd1);

    // Drop enable mid-frame: the frame still finishes.
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    chk("fc_after_disable", {16'h0, frame_cnt}, 32'd4);
    chk("idle_after_disable", {23'h0, busy, data}, 32'h0);

    // Power-down pulse mid-frame: abort without counting.
    pattern_sel = 2'd3;
    enable      = 1'b1;
    repeat (46) @(negedge clk);
    sensor_pwdn = 1'b1;
    @(negedge clk);
    sensor_pwdn = 1'b0;
    chk("fc_after_pwdn", {16'h0, frame_cnt}, 32'd4);
    repeat (100) @(negedge clk);

    // Sensor reset mid-frame, then resume with the ramp pattern.
    sensor_rstn = 1'b0;
    repeat (2) @(negedge clk);
    sensor_rstn = 1'b1;
    pattern_sel = 2'd0;
    repeat (90) @(negedge clk);
    enable = 1'b0;
    begin
      int t;
      t = 0;
      while (busy && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("final_idle", {31'h0, busy}, 32'h0);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bt656_stream_gen.md
# bt656_stream_gen

Source-side emulator for the BT.656/DVP camera stream: generates complete YCbCr 4:2:2 frames with embedded EAV/SAV timing codes plus parallel HREF/HSYNC/VSYNC strobes, one byte per clock. It drives the source side of the team's BT.656 stream interface so that the capture path can run without an OV5642/ADV7280 attached, and it serves as the stimulus engine in capture-path benches. The stream pixel clock is `clk_i`; the block emits no separate clock.

## Interface
- `DW`, 8: data width; only 8 is supported.
- `H_ACTIVE`, 640: active pixels per line, sent as 2*H_ACTIVE bytes.
- `H_BLANK`, 268: blanking fill bytes between EAV and SAV; must be even and ≥ 2.
- `V_ACTIVE`, 480: active lines per frame.
- `V_BLANK`, 45: vertical blanking lines per frame; must be ≥ 1.
- `VSYNC_LINES`, 3: number of leading blanking lines with VSYNC high; must be ≤ V_BLANK.

Ports:
- `clk_i`  in  1: clock (the stream PCLK).
- `rstn_i`  in  1: asynchronous active-low reset.
- `enable_i`  in  1: run request; level-sensitive.
- `pattern_sel_i`  in  2: 0 ramp, 1 flat white, 2 line number, 3 checker.
- `sensor_rstn_i`  in  1: interface RSTN, sensor reset (active low).
- `sensor_pwdn_i`  in  1: interface PWDN, sensor power-down (active high).
- `data_o`  out  DW: stream DATA.
- `href_o`  out  1: high on active bytes of active lines only.
- `hsync_o`  out  1: high from EAV byte 0 through the last blanking byte.
- `vsync_o`  out  1: high on every byte of lines 0..VSYNC_LINES-1.
- `busy_o`  out  1: high while a frame is in progress.
- `frame_cnt_o`  out  16: completed frames; wraps from 0xFFFF to 0.

## Operation
- Line layout, LINE_BYTES = 8+H_BLANK+2*H_ACTIVE; h_cnt runs 0..LINE_BYTES-1: EAV (FF,00,00,XY), blanking fill (80,10 repeating), SAV (FF,00,00,XY), active bytes (Cb,Y,Cr,Y ...).
- Frame layout: v_cnt runs 0..V_BLANK+V_ACTIVE-1. Lines below V_BLANK are blanking (V=1); the remaining lines are active. On blanking lines the active region carries 80,10 fill and href_o stays low.
- XY byte = {1, F=0, V, H, P3=V^H, P2=F^H, P1=F^V, P0=F^V^H}. Resulting codes: active SAV 0x80, active EAV 0x9D, blanking SAV 0xAB, blanking EAV 0xB6.
- Active byte index k = h_cnt-(8+H_BLANK). Chroma bytes are those with k even.
- Pattern 0: byte = k[7:0].
- Pattern 1: Y = 0xEB, chroma = 0x80.
- Pattern 2: every byte = (v_cnt-V_BLANK)[7:0].
- Pattern 3: Y = 0xEB when pixel (k>>1) bit 3 XOR active-line bit 3 is set, otherwise 0x10; chroma = 0x80.
- Clip: any active byte equal to 0x00 is sent as 0x01, and 0xFF as 0xFE. Only timing codes may carry 0x00 or 0xFF.
- pattern_sel_i is sampled once at frame start and held for the whole frame.
- States:
  - IDLE: outputs at idle values. Go to RUN when enable_i=1, sensor_rstn_i=1 and sensor_pwdn_i=0.
  - RUN: counters advance every cycle. At the last byte of the last line, frame_cnt_o increments, then RUN restarts at v=0,h=0 if the run conditions still hold, otherwise the block goes to IDLE.
- enable_i deasserted mid-frame: the current frame completes, then IDLE.
- sensor_rstn_i=0 or sensor_pwdn_i=1 at any time: IDLE on the next clock; counters clear; frame_cnt_o is not incremented. The next start is at a frame boundary.
- Idle values (also the reset values): data_o=0x00, href_o=0, hsync_o=0, vsync_o=0, busy_o=0, frame_cnt_o=0.

## Timing
- All outputs are registered. The byte for counter state (v,h) appears on data_o one clock after that state.
- Start-up: with run conditions sampled true at edge N, data_o=0xFF (blanking EAV byte 0) follows edge N+1, and busy_o=1 from edge N+1.
- Back-to-back frames: no idle gap. The last byte of frame n is followed directly by EAV 0xFF of frame n+1.
- frame_cnt_o updates on the same edge that presents the first byte of the next frame, or the first idle cycle.
- href_o, hsync_o and vsync_o are aligned to the same cycle as the data_o byte they qualify.
- busy_o falls together with the first idle data_o.

## Test plan
Small parameters for all scenarios: H_ACTIVE=4, H_BLANK=4, V_ACTIVE=2, V_BLANK=2, VSYNC_LINES=1 (LINE_BYTES=20, 80 bytes per frame).
- Reset then enable with pattern 0 → line 0 = FF 00 00 B6 80 10 80 10 FF 00 00 AB, then 8 fill bytes. vsync_o high for 20 cycles. href_o low throughout.
- Line 2 of the same frame → EAV code 9D, SAV code 80, active bytes 01 01 02 03 04 05 06 07 with href_o high for exactly 8 cycles.
- Hold enable_i high for 3 frames → contiguous 240-byte stream; frame_cnt_o steps 1, 2, 3 at bytes 80, 160, 240; busy_o never drops.
- Deassert enable_i at byte 30 → frame finishes at byte 80, then data_o=0 and busy_o=0; frame_cnt_o=1.
- Pulse sensor_pwdn_i at byte 45 → idle on the next cycle, frame_cnt_o unchanged. After release, the stream restarts with FF 00 00 B6.
- Pattern 1 → active bytes 80 EB 80 EB. Pattern 2 on active line 1 → 01 01 01 ... (0x00 clipped). Switching pattern_sel_i mid-frame takes effect only at the next frame.
